// File: rtl/gray_dec_pkg.sv
// Shared types and constants for the gray-to-binary FIFO-word repacker.
// Includes the data_count validation helpers used by gray_dec.
package gray_dec_pkg;

   localparam int SEG_W  = 16;
   localparam int NSEG   = 8;
   localparam int FIFO_W = 140;
   localparam int DATA_W = 128;
   localparam int CH_W   = 8;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

   function automatic logic cnt_legal(input logic [15:0] cnt);
      return (cnt[3:0] == 4'd0) && (cnt <= 16'd128);
   endfunction

   // Illegal lengths collapse to zero segments so they flow straight to DONE.
   function automatic logic [CNT_W-1:0] calc_n(input logic [15:0] cnt);
      return cnt_legal(cnt) ? cnt[7:4] : '0;
   endfunction

endpackage

// File: rtl/gray_seg_dec.sv
// One segment of gray-to-binary decode: MSB-first prefix XOR seeded by the
// LSB of the previously decoded segment.
module gray_seg_dec
   import gray_dec_pkg::*;
#(
   parameter int W = SEG_W
) (
   input  logic [W-1:0] g,
   input  logic         carry_in,
   output logic [W-1:0] b,
   output logic         carry_out
);

   always_comb begin
      logic acc;
      b   = '0;
      acc = carry_in;
      for (int i = W - 1; i >= 0; i--) begin
         acc  = acc ^ g[i];
         b[i] = acc;
      end
   end

   assign carry_out = b[0];

endmodule

// File: rtl/gray_dec.sv
// Gray-to-binary decoder and FIFO-word repacker, one 16-bit segment per cycle.
// Optional illegal-length flag err_len is built when GRAY_DEC_ERR_EN is defined.
module gray_dec #(
   parameter int SEG_W = 16,
   parameter int NSEG  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SEG_W*NSEG-1:0]    data_gray,
   input  logic [7:0]               vld_ch,
   input  logic [15:0]              data_count,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SEG_W*NSEG+11:0]   data_to_fifo
`ifdef GRAY_DEC_ERR_EN
   ,
   output logic                     err_len
`endif
);
   import gray_dec_pkg::CH_W;
   import gray_dec_pkg::CNT_W;
   import gray_dec_pkg::state_t;
   import gray_dec_pkg::IDLE;
   import gray_dec_pkg::DECODE;
   import gray_dec_pkg::DONE;
   import gray_dec_pkg::calc_n;
   import gray_dec_pkg::cnt_legal;

   localparam int LW = SEG_W * NSEG;
   localparam int KW = $clog2(NSEG);

   state_t            r_state;
   logic [LW-1:0]     r_gray;
   logic [LW-1:0]     r_data;
   logic [CH_W-1:0]   r_ch;
   logic [CNT_W-1:0]  r_n;
   logic [KW-1:0]     r_k;
   logic              r_carry;
   logic              r_in_ready;
   logic              r_out_valid;

   logic [SEG_W-1:0]  w_seg_b;
   logic              w_carry;
   logic [CNT_W-1:0]  w_n;
   logic              w_last;
   logic              w_accept;

   assign w_n      = calc_n(data_count);
   assign w_last   = (CNT_W'(r_k) == (r_n - CNT_W'(1)));
   assign w_accept = (r_state == IDLE) && in_valid;

   // The gray word is shifted left each DECODE cycle so segment k is always on top.
   gray_seg_dec #(.W(SEG_W)) u_seg (
      .g         (r_gray[LW-1 -: SEG_W]),
      .carry_in  (r_carry),
      .b         (w_seg_b),
      .carry_out (w_carry)
   );

   always_ff @(posedge clk) begin
      if (w_accept)
         r_gray <= data_gray;
      else if (r_state == DECODE)
         r_gray <= r_gray << SEG_W;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_data      <= '0;
         r_ch        <= '0;
         r_n         <= '0;
         r_k         <= '0;
         r_carry     <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_ch       <= vld_ch;
                  r_n        <= w_n;
                  r_data     <= '0;
                  r_k        <= '0;
                  r_carry    <= 1'b0;
                  r_in_ready <= 1'b0;
                  if (w_n == '0) begin
                     r_state     <= DONE;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state <= DECODE;
                  end
               end
            end
            DECODE: begin
               for (int s = 0; s < NSEG; s++)
                  if (r_k == KW'(s))
                     r_data[LW-1-s*SEG_W -: SEG_W] <= w_seg_b;
               r_carry <= w_carry;
               if (w_last) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

`ifdef GRAY_DEC_ERR_EN
   logic r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_err <= 1'b0;
      else if (w_accept)
         r_err <= !cnt_legal(data_count);
      else if ((r_state == DONE) && out_ready)
         r_err <= 1'b0;
   end

   assign err_len = r_err;
`else
   logic w_unused_legal;
   assign w_unused_legal = cnt_legal(data_count);
`endif

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign data_to_fifo = {r_data, r_ch, r_n};

endmodule

// File: tb/tb_gray_dec.sv
// Directed bench for gray_dec: single/multi-segment decode, full-word round trip,
// illegal lengths, backpressure and reset during decode.
module tb_gray_dec;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [127:0]  data_gray;
   logic [7:0]    vld_ch;
   logic [15:0]   data_count;
   logic          out_valid;
   logic          out_ready;
   logic [139:0]  data_to_fifo;
`ifdef GRAY_DEC_ERR_EN
   logic          err_len;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [127:0] b1, b2, g1, g2;
   logic [139:0] exp_w;
   logic [15:0]  bad_cnt [3];
   logic         saw_valid;

   always #5 clk = ~clk;

   gray_dec dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .data_gray    (data_gray),
      .vld_ch       (vld_ch),
      .data_count   (data_count),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .data_to_fifo (data_to_fifo)
`ifdef GRAY_DEC_ERR_EN
      ,
      .err_len      (err_len)
`endif
   );

   task automatic check(input string tag, input logic [139:0] obs, input logic [139:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] cnt, input logic [127:0] g, input logic [7:0] ch);
      data_count = cnt;
      data_gray  = g;
      vld_ch     = ch;
      in_valid   = 1'b1;
      tick();
      in_valid   = 1'b0;
      check("accept_in_ready", 140'(in_ready), 140'(0));
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hs_out_valid", 140'(out_valid), 140'(0));
      check("hs_in_ready", 140'(in_ready), 140'(1));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      bad_cnt[0] = 16'd0;
      bad_cnt[1] = 16'd24;
      bad_cnt[2] = 16'd144;
      b1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      b2 = 128'hDEAD_BEEF_0000_FFFF_A5A5_5A5A_1357_9BDF;
      g1 = b1 ^ (b1 >> 1);
      g2 = b2 ^ (b2 >> 1);

      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      data_gray  = '0;
      vld_ch     = '0;
      data_count = '0;
      tick();
      tick();
      check("rst_in_ready", 140'(in_ready), 140'(1));
      check("rst_out_valid", 140'(out_valid), 140'(0));
      check("rst_data", data_to_fifo, 140'(0));
`ifdef GRAY_DEC_ERR_EN
      check("rst_err", 140'(err_len), 140'(0));
`endif
      rst = 1'b0;
      tick();
      check("idle_in_ready", 140'(in_ready), 140'(1));

      // Single segment
      send(16'd16, {16'h8000, 112'h0}, 8'hA5);
      check("t1_not_yet", 140'(out_valid), 140'(0));
      tick();
      check("t1_valid", 140'(out_valid), 140'(1));
      check("t1_data", data_to_fifo, {16'hFFFF, 112'h0, 8'hA5, 4'd1});
      handshake();

      // Two segments: carry out of segment 0 (LSB=1) seeds segment 1
      send(16'd32, {32'h0001_8000, 96'h0}, 8'h5A);
      tick();
      check("t2_lat1", 140'(out_valid), 140'(0));
      tick();
      check("t2_valid", 140'(out_valid), 140'(1));
      check("t2_data", data_to_fifo, {32'h0001_0000, 96'h0, 8'h5A, 4'd2});
      handshake();

      // Full word round trip, out_ready tied high, back-to-back words
      out_ready  = 1'b1;
      data_count = 16'd128;
      data_gray  = g1;
      vld_ch     = 8'hC3;
      in_valid   = 1'b1;
      tick();
      data_gray  = g2;
      vld_ch     = 8'h3C;
      repeat (7) tick();
      check("t3_lat7", 140'(out_valid), 140'(0));
      tick();
      check("t3_lat8", 140'(out_valid), 140'(1));
      check("t3_data1", data_to_fifo, {b1, 8'hC3, 4'd8});
      tick();
      check("t3_hs_valid", 140'(out_valid), 140'(0));
      check("t3_hs_ready", 140'(in_ready), 140'(1));
      tick();
      check("t3_accept2", 140'(in_ready), 140'(0));
      repeat (7) tick();
      check("t3_w2_lat7", 140'(out_valid), 140'(0));
      tick();
      check("t3_w2_valid", 140'(out_valid), 140'(1));
      check("t3_data2", data_to_fifo, {b2, 8'h3C, 4'd8});
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      check("t3_w2_hs", 140'(out_valid), 140'(0));

      // Zero and illegal lengths
      for (int i = 0; i < 3; i++) begin
         send(bad_cnt[i], '1, 8'(8'h11 * (i + 1)));
         check("t4_valid", 140'(out_valid), 140'(1));
         check("t4_data", data_to_fifo, {128'h0, 8'(8'h11 * (i + 1)), 4'd0});
`ifdef GRAY_DEC_ERR_EN
         check("t4_err", 140'(err_len), 140'(i != 0));
`endif
         handshake();
`ifdef GRAY_DEC_ERR_EN
         check("t4_err_clr", 140'(err_len), 140'(0));
`endif
      end

      // Backpressure with a pending upstream word
      send(16'd16, {16'h1234, 112'h0}, 8'h77);
      tick();
      exp_w = {16'h1C27, 112'h0, 8'h77, 4'd1};
      check("t5_valid", 140'(out_valid), 140'(1));
      check("t5_data", data_to_fifo, exp_w);
      data_count = 16'd16;
      data_gray  = {16'h8000, 112'h0};
      vld_ch     = 8'h3C;
      in_valid   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t5_hold_valid", 140'(out_valid), 140'(1));
         check("t5_hold_data", data_to_fifo, exp_w);
         check("t5_hold_ready", 140'(in_ready), 140'(0));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t5_hs_valid", 140'(out_valid), 140'(0));
      check("t5_hs_ready", 140'(in_ready), 140'(1));
      tick();
      in_valid = 1'b0;
      check("t5_accept", 140'(in_ready), 140'(0));
      tick();
      check("t5_next_valid", 140'(out_valid), 140'(1));
      check("t5_next_data", data_to_fifo, {16'hFFFF, 112'h0, 8'h3C, 4'd1});
      handshake();

      // Reset while decoding segment 3 of a full word
      send(16'd128, g1, 8'h99);
      repeat (3) tick();
      check("t6_busy", 140'(in_ready), 140'(0));
      rst = 1'b1;
      #1;
      check("t6_rst_ready", 140'(in_ready), 140'(1));
      check("t6_rst_valid", 140'(out_valid), 140'(0));
      check("t6_rst_data", data_to_fifo, 140'(0));
      tick();
      rst = 1'b0;
      saw_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid) saw_valid = 1'b1;
      end
      out_ready = 1'b0;
      check("t6_no_output", 140'(saw_valid), 140'(0));
      send(16'd32, {32'h0001_8000, 96'h0}, 8'h42);
      tick();
      tick();
      check("t6_after_valid", 140'(out_valid), 140'(1));
      check("t6_after_data", data_to_fifo, {32'h0001_0000, 96'h0, 8'h42, 4'd2});
      handshake();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
